// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
//   Pipelined Rijndael ShiftRows / InvShiftRows with valid/ready flow control.
//   The byte permutation is combinational ahead of stage 0. Stages 1..PIPE-1
//   only register {valid, tag, data}. Latency is PIPE cycles, and throughput is
//   1 beat/cycle.
//
//   Parameters: NB (4/6/8 columns), PIPE (1..4 stages), TAG_W (>=1).
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     in_valid/in_ready         upstream handshake
//     in_inv                    0 = ShiftRows, 1 = InvShiftRows (per beat)
//     in_tag, in_data           sideband tag, column-major state
//                               (s[r][c] = data[DW-1-8*(4c+r) -: 8])
//     out_valid/out_ready       downstream handshake
//     out_tag, out_data         tag and transformed state of the output beat
//     par_err                   only when SHIFT_ROWS_PARITY_EN is defined
//
//   SHIFT_ROWS_PARITY_EN: stage 0 captures the four row parities of in_data.
//   ShiftRows only moves bytes within a row, so the parities are unchanged by
//   the permutation. par_err flags an output beat whose recomputed row
//   parities disagree with the captured ones.
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int PIPE  = 1,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [32*NB-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TAG_W-1:0]   out_tag,
    output logic [32*NB-1:0]   out_data
`ifdef SHIFT_ROWS_PARITY_EN
    ,
    output logic               par_err
`endif
);

    localparam int          DW  = 32 * NB;
    localparam int unsigned NBU = NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
        $error("shift_rows_pipe: PIPE must be 1..4");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shift_rows_pipe: TAG_W must be >= 1");
    end

    // Row offsets are {0,1,2,3}. The 256-bit block instead uses {0,1,3,4}.
    function automatic int unsigned row_off(input int unsigned r);
        if (NB == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    logic [DW-1:0]    perm_data;
    logic [PIPE-1:0]  v;
    logic [DW-1:0]    data_q    [PIPE];
    logic [TAG_W-1:0] tag_q     [PIPE];
    logic [PIPE-1:0]  rdy;
    logic [PIPE-1:0]  stg_v;
    logic [DW-1:0]    stg_data  [PIPE];
    logic [TAG_W-1:0] stg_tag   [PIPE];

    always_comb begin
        perm_data = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < NBU; c++) begin
                int unsigned src;
                src = in_inv ? (c + NBU - row_off(r)) % NBU
                             : (c + row_off(r)) % NBU;
                perm_data[DW-1-8*(4*c+r) -: 8] = in_data[DW-1-8*(4*src+r) -: 8];
            end
        end
    end

    // Stage k may load when any stage from k to the output is empty, or when
    // the output is being drained. Writing this as a closed form avoids a
    // self-referential ready chain.
    always_comb begin
        rdy = '0;
        for (int unsigned k = 0; k < PIPE; k++) begin
            logic all_full;
            all_full = 1'b1;
            for (int unsigned j = k; j < PIPE; j++) begin
                all_full = all_full & v[j];
            end
            rdy[k] = out_ready | ~all_full;
        end
    end

    always_comb begin
        stg_v       = '0;
        stg_v[0]    = in_valid;
        stg_data[0] = perm_data;
        stg_tag[0]  = in_tag;
        for (int unsigned k = 1; k < PIPE; k++) begin
            stg_v[k]    = v[k-1];
            stg_data[k] = data_q[k-1];
            stg_tag[k]  = tag_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int unsigned k = 0; k < PIPE; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < PIPE; k++) begin
                if (rdy[k]) begin
                    v[k] <= stg_v[k];
                    if (stg_v[k]) begin
                        data_q[k] <= stg_data[k];
                        tag_q[k]  <= stg_tag[k];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[PIPE-1];
    assign out_data  = data_q[PIPE-1];
    assign out_tag   = tag_q[PIPE-1];

`ifdef SHIFT_ROWS_PARITY_EN
    function automatic logic [3:0] row_parity(input logic [DW-1:0] d);
        logic [3:0] p;
        p = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < NBU; c++) begin
                p[r[1:0]] = p[r[1:0]] ^ (^d[DW-1-8*(4*c+r) -: 8]);
            end
        end
        return p;
    endfunction

    logic [3:0] par_q [PIPE];
    logic [3:0] stg_par [PIPE];

    always_comb begin
        stg_par[0] = row_parity(in_data);
        for (int unsigned k = 1; k < PIPE; k++) begin
            stg_par[k] = par_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < PIPE; k++) begin
                par_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < PIPE; k++) begin
                if (rdy[k] && stg_v[k]) begin
                    par_q[k] <= stg_par[k];
                end
            end
        end
    end

    assign par_err = v[PIPE-1] && (row_parity(data_q[PIPE-1]) != par_q[PIPE-1]);
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe. It uses three configurations:
//   p1 : NB=4, PIPE=1 with the FIPS-197 vectors and one-cycle latency.
//   p3 : NB=4, PIPE=3 with backpressure, mid-stream reset and random traffic.
//   w8 : NB=8, PIPE=2 chained into a second NB=8 instance. The second
//        instance's mode is taken from tag bit 0.
// Expected values come from a queue-rotation model of the row shifts.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Rows are rotated left (forward) or right (inverse) by whole byte steps.
    function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d, input logic inv);
        logic [255:0] res;
        int offs [4];
        res = '0;
        offs = (nb == 8) ? '{0, 1, 3, 4} : '{0, 1, 2, 3};
        for (int r = 0; r < 4; r++) begin
            logic [7:0] q [$];
            for (int c = 0; c < nb; c++) q.push_back(d[32*nb-8-8*(4*c+r) +: 8]);
            repeat (offs[r]) begin
                if (!inv) q.push_back(q.pop_front());
                else      q.push_front(q.pop_back());
            end
            for (int c = 0; c < nb; c++) res[32*nb-8-8*(4*c+r) +: 8] = q[c];
        end
        return res;
    endfunction

    typedef struct packed {
        logic [255:0] d;
        logic [7:0]   tag;
    } beat_t;

    // ---------------- p1: NB=4, PIPE=1 ----------------
    logic         rst1 = 1'b1, p1_valid = 1'b0, p1_inv = 1'b0, p1_ordy = 1'b0;
    logic [3:0]   p1_tag = '0, p1_out_tag;
    logic [127:0] p1_data = '0, p1_out_data;
    logic         p1_in_ready, p1_out_valid;

    // ---------------- p3: NB=4, PIPE=3 ----------------
    logic         rst = 1'b1, p3_valid = 1'b0, p3_inv = 1'b0, p3_ordy = 1'b0;
    logic [3:0]   p3_tag = '0, p3_out_tag;
    logic [127:0] p3_data = '0, p3_out_data;
    logic         p3_in_ready, p3_out_valid;

    // ---------------- w8 chain: NB=8, PIPE=2 x2 ----------------
    logic         rst8 = 1'b1, w8_valid = 1'b0, w8_inv = 1'b0, w8b_ordy = 1'b0;
    logic [3:0]   w8_tag = '0, w8_out_tag, w8b_out_tag;
    logic [255:0] w8_data = '0, w8_out_data, w8b_out_data;
    logic         w8_in_ready, w8_out_valid, w8b_in_ready, w8b_out_valid;

`ifdef SHIFT_ROWS_PARITY_EN
    logic p1_par_err, p3_par_err, w8_par_err, w8b_par_err;
`endif

    shift_rows_pipe #(.NB(4), .PIPE(1), .TAG_W(4)) u_p1 (
        .clk(clk), .rst(rst1), .in_valid(p1_valid), .in_ready(p1_in_ready),
        .in_inv(p1_inv), .in_tag(p1_tag), .in_data(p1_data),
        .out_valid(p1_out_valid), .out_ready(p1_ordy), .out_tag(p1_out_tag),
        .out_data(p1_out_data)
`ifdef SHIFT_ROWS_PARITY_EN
        , .par_err(p1_par_err)
`endif
    );

    shift_rows_pipe #(.NB(4), .PIPE(3), .TAG_W(4)) u_p3 (
        .clk(clk), .rst(rst), .in_valid(p3_valid), .in_ready(p3_in_ready),
        .in_inv(p3_inv), .in_tag(p3_tag), .in_data(p3_data),
        .out_valid(p3_out_valid), .out_ready(p3_ordy), .out_tag(p3_out_tag),
        .out_data(p3_out_data)
`ifdef SHIFT_ROWS_PARITY_EN
        , .par_err(p3_par_err)
`endif
    );

    shift_rows_pipe #(.NB(8), .PIPE(2), .TAG_W(4)) u_w8 (
        .clk(clk), .rst(rst8), .in_valid(w8_valid), .in_ready(w8_in_ready),
        .in_inv(w8_inv), .in_tag(w8_tag), .in_data(w8_data),
        .out_valid(w8_out_valid), .out_ready(w8b_in_ready), .out_tag(w8_out_tag),
        .out_data(w8_out_data)
`ifdef SHIFT_ROWS_PARITY_EN
        , .par_err(w8_par_err)
`endif
    );

    shift_rows_pipe #(.NB(8), .PIPE(2), .TAG_W(4)) u_w8b (
        .clk(clk), .rst(rst8), .in_valid(w8_out_valid), .in_ready(w8b_in_ready),
        .in_inv(w8_out_tag[0]), .in_tag(w8_out_tag), .in_data(w8_out_data),
        .out_valid(w8b_out_valid), .out_ready(w8b_ordy), .out_tag(w8b_out_tag),
        .out_data(w8b_out_data)
`ifdef SHIFT_ROWS_PARITY_EN
        , .par_err(w8b_par_err)
`endif
    );

    // ---------------- scoreboards (sampled on negedge) ----------------
    beat_t q3 [$];
    beat_t q8a [$];
    beat_t q8b [$];
    logic         held3 = 1'b0;
    logic [127:0] held_d;
    logic [3:0]   held_t;

    always @(negedge clk) begin
        beat_t e;
        if (held3) begin
            check("p3 hold valid", 256'(p3_out_valid), 256'(1));
            check("p3 hold data", 256'(p3_out_data), 256'(held_d));
            check("p3 hold tag", 256'(p3_out_tag), 256'(held_t));
        end
        if (rst) begin
            q3.delete();
            held3 = 1'b0;
        end else begin
            if (p3_out_valid && p3_ordy) begin
                if (q3.size() == 0) begin
                    check("p3 spurious beat", 256'(1), 256'(0));
                end else begin
                    e = q3.pop_front();
                    check("p3 data", 256'(p3_out_data), e.d);
                    check("p3 tag", 256'(p3_out_tag), 256'(e.tag));
                end
            end
`ifdef SHIFT_ROWS_PARITY_EN
            if (p3_out_valid) check("p3 par_err", 256'(p3_par_err), 256'(0));
`endif
            if (p3_valid && p3_in_ready) begin
                e.d   = ref_shift(4, 256'(p3_data), p3_inv);
                e.tag = 8'(p3_tag);
                q3.push_back(e);
            end
            held3  = p3_out_valid && !p3_ordy;
            held_d = p3_out_data;
            held_t = p3_out_tag;
        end
    end

    always @(negedge clk) begin
        beat_t e, f;
        if (rst8) begin
            q8a.delete();
            q8b.delete();
        end else begin
            if (w8_out_valid && w8b_in_ready) begin
                if (q8a.size() == 0) begin
                    check("w8 spurious beat", 256'(1), 256'(0));
                end else begin
                    e = q8a.pop_front();
                    check("w8 data", w8_out_data, e.d);
                    check("w8 tag", 256'(w8_out_tag), 256'(e.tag));
                    f.d   = ref_shift(8, e.d, e.tag[0]);
                    f.tag = e.tag;
                    q8b.push_back(f);
                end
            end
            if (w8b_out_valid && w8b_ordy) begin
                if (q8b.size() == 0) begin
                    check("w8b spurious beat", 256'(1), 256'(0));
                end else begin
                    e = q8b.pop_front();
                    check("w8b data", w8b_out_data, e.d);
                    check("w8b tag", 256'(w8b_out_tag), 256'(e.tag));
                end
            end
            if (w8_valid && w8_in_ready) begin
                e.d   = ref_shift(8, w8_data, w8_inv);
                e.tag = 8'(w8_tag);
                q8a.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] asc;
        int t, cyc, accepts;

        repeat (3) tick();
        @(negedge clk);
        check("rst out_valid", 256'(p3_out_valid), 256'(0));
        check("rst out_data", 256'(p3_out_data), 256'(0));
        check("rst out_tag", 256'(p3_out_tag), 256'(0));
        check("rst p1 out_valid", 256'(p1_out_valid), 256'(0));
        check("rst w8 out_valid", 256'(w8_out_valid), 256'(0));
        tick();
        rst = 1'b0; rst1 = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        check("in_ready after rst", 256'(p3_in_ready), 256'(1));

        // T1 / T2: FIPS-197 vectors, one cycle of latency.
        tick();
        p1_valid = 1'b1; p1_inv = 1'b0; p1_tag = 4'd5; p1_ordy = 1'b1;
        p1_data = 128'hd42711aee0bf98f1b8b45de51e415230;
        @(negedge clk);
        check("T1 in_ready", 256'(p1_in_ready), 256'(1));
        tick();
        p1_inv = 1'b1; p1_tag = 4'd6;
        p1_data = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        @(negedge clk);
        check("T1 out_valid", 256'(p1_out_valid), 256'(1));
        check("T1 out_data", 256'(p1_out_data), 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
        check("T1 out_tag", 256'(p1_out_tag), 256'(5));
        tick();
        p1_valid = 1'b0;
        @(negedge clk);
        check("T2 out_valid", 256'(p1_out_valid), 256'(1));
        check("T2 out_data", 256'(p1_out_data), 256'(128'hd42711aee0bf98f1b8b45de51e415230));
        check("T2 out_tag", 256'(p1_out_tag), 256'(6));
        tick();
        @(negedge clk);
        check("T2 no duplicate", 256'(p1_out_valid), 256'(0));

        // T3: NB=8 ascending bytes, then a round trip through the chain.
        for (int i = 0; i < 32; i++) asc[255-8*i -: 8] = 8'(i);
        tick();
        w8_valid = 1'b1; w8_data = asc; w8_inv = 1'b0; w8_tag = 4'd1; w8b_ordy = 1'b1;
        tick();
        w8_valid = 1'b0;
        tick();
        @(negedge clk);
        check("T3 w8 out_valid", 256'(w8_out_valid), 256'(1));
        for (int c = 0; c < 8; c++) begin
            check("T3 row3 byte", 256'(w8_out_data[255-8*(4*c+3) -: 8]),
                  256'(4 * ((c + 4) % 8) + 3));
        end
        tick();
        tick();
        @(negedge clk);
        check("T3 roundtrip valid", 256'(w8b_out_valid), 256'(1));
        check("T3 roundtrip data", w8b_out_data, asc);

        for (int i = 0; i < 250; i++) begin
            tick();
            w8_valid = ($urandom_range(0, 3) != 0);
            w8_inv   = 1'($urandom);
            w8_tag   = 4'($urandom);
            w8_data  = {rnd128(), rnd128()};
            w8b_ordy = ($urandom_range(0, 2) != 0);
        end
        tick();
        w8_valid = 1'b0; w8b_ordy = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("w8 drained", 256'(q8a.size() + q8b.size()), 256'(0));

        // T4: backpressure on PIPE=3, tags 0..9 held until accepted.
        t = 0; cyc = 0; accepts = 0;
        while (t < 10 && cyc < 60) begin
            tick();
            p3_valid = 1'b1; p3_tag = 4'(t); p3_inv = 1'($urandom); p3_data = rnd128();
            p3_ordy  = (cyc >= 9);
            @(negedge clk);
            if (cyc == 8) begin
                check("T4 accepts before full", 256'(accepts), 256'(3));
                check("T4 in_ready full", 256'(p3_in_ready), 256'(0));
            end
            if (p3_in_ready) begin
                t++;
                accepts++;
            end
            cyc++;
        end
        check("T4 all accepted", 256'(t), 256'(10));
        tick();
        p3_valid = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        check("T4 drained", 256'(q3.size()), 256'(0));

        // T5: reset with two beats in flight.
        tick();
        p3_valid = 1'b1; p3_ordy = 1'b0; p3_tag = 4'd12; p3_data = rnd128();
        tick();
        p3_tag = 4'd13; p3_data = rnd128();
        tick();
        p3_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        p3_valid = 1'b1; p3_ordy = 1'b1; p3_tag = 4'd3; p3_data = rnd128();
        @(negedge clk);
        check("T5 out_valid after rst", 256'(p3_out_valid), 256'(0));
        check("T5 in_ready after rst", 256'(p3_in_ready), 256'(1));
        tick();
        p3_valid = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("T5 drained", 256'(q3.size()), 256'(0));

        // Random traffic with random backpressure on PIPE=3.
        for (int i = 0; i < 400; i++) begin
            tick();
            p3_valid = ($urandom_range(0, 3) != 0);
            p3_inv   = 1'($urandom);
            p3_tag   = 4'($urandom);
            p3_data  = rnd128();
            p3_ordy  = ($urandom_range(0, 2) != 0);
        end
        tick();
        p3_valid = 1'b0; p3_ordy = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check("random drained", 256'(q3.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
